// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Latency: grant at the IDLE edge, SETUP next cycle, ACCESS after; zero-wait response 3 cycles after request.
// Backpressure: requests are held off (no req_ready_out) while a transfer is in SETUP/ACCESS; PREADY stalls ACCESS up to TIMEOUT_CYCLE.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 16
) (
  input  logic                               apb_clk_in,
  input  logic                               apb_rst_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr_in,
  input  logic [NUM_REQ-1:0]                 req_write_in,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [NUM_REQ-1:0]                 rsp_valid_out,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_out,
  output logic                               rsp_error_out,
  output logic                               apb_psel_out,
  output logic                               apb_penable_out,
  output logic [APB_ADDR_WIDTH-1:0]          apb_addr_out,
  output logic                               apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]          apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0]          apb_rdata_in,
  input  logic                               apb_ready_in,
  input  logic                               apb_slverr_in
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SETUP  = 3'b010,
    S_ACCESS = 3'b100
  } state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_ptr;
  logic [PW-1:0]             r_gnt;
  logic [CW-1:0]             r_cnt;
  logic [NUM_REQ-1:0]        r_req_ready;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_error;
  logic                      r_psel;
  logic                      r_penable;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;

  logic [PW-1:0]             w_gnt;
  logic                      w_gnt_vld;
  logic [PW-1:0]             w_ptr_nxt;
  logic [NUM_REQ-1:0]        w_gnt_oh;
  logic [NUM_REQ-1:0]        w_rsp_oh;

  // Round-robin search: first valid requester at or after the pointer, wrapping to 0.
  always_comb begin
    logic [PW:0] sum;
    w_gnt     = r_ptr;
    w_gnt_vld = 1'b0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      if (!w_gnt_vld && req_valid_in[sum[PW-1:0]]) begin
        w_gnt     = sum[PW-1:0];
        w_gnt_vld = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == PW'(NUM_REQ - 1)) ? '0 : w_gnt + PW'(1);
  assign w_gnt_oh  = NUM_REQ'(1) << w_gnt;
  assign w_rsp_oh  = NUM_REQ'(1) << r_gnt;

  // Transfer FSM: arbitrate in IDLE, then SETUP and ACCESS with a wait-state timeout.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt       <= w_gnt;
            r_ptr       <= w_ptr_nxt;
            r_req_ready <= w_gnt_oh;
            r_addr      <= req_addr_in[int'(w_gnt)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            r_write     <= req_write_in[w_gnt];
            r_wdata     <= req_wdata_in[int'(w_gnt)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb_ready_in) begin
            r_rsp_valid <= w_rsp_oh;
            r_rsp_rdata <= r_write ? '0 : apb_rdata_in;
            r_rsp_error <= apb_slverr_in;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else if (r_cnt == CW'(TIMEOUT_CYCLE - 1)) begin
            // Slave never answered: abort and report an error to the owner.
            r_rsp_valid <= w_rsp_oh;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_out   = r_req_ready;
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_rdata_out   = r_rsp_rdata;
  assign rsp_error_out   = r_rsp_error;
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;
  assign apb_addr_out    = r_addr;
  assign apb_write_out   = r_write;
  assign apb_wdata_out   = r_wdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model and a scripted APB slave.
module tb_apb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    rsp_valid_out;
  logic [DW-1:0]   rsp_rdata_out;
  logic            rsp_error_out;
  logic            apb_psel_out;
  logic            apb_penable_out;
  logic [AW-1:0]   apb_addr_out;
  logic            apb_write_out;
  logic [DW-1:0]   apb_wdata_out;
  logic [DW-1:0]   apb_rdata_in = '0;
  logic            apb_ready_in = 1'b0;
  logic            apb_slverr_in = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_seen = 0;
  int slave_wait = 0;
  bit slave_never = 1'b0;
  bit slave_err = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  int model_ptr = 0;

  apb_master_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLE(TO)) dut (
    .apb_clk_in(clk), .apb_rst_in(rst),
    .req_valid_in(req_valid), .req_addr_in(req_addr), .req_write_in(req_write), .req_wdata_in(req_wdata),
    .req_ready_out(req_ready_out), .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out),
    .rsp_error_out(rsp_error_out), .apb_psel_out(apb_psel_out), .apb_penable_out(apb_penable_out),
    .apb_addr_out(apb_addr_out), .apb_write_out(apb_write_out), .apb_wdata_out(apb_wdata_out),
    .apb_rdata_in(apb_rdata_in), .apb_ready_in(apb_ready_in), .apb_slverr_in(apb_slverr_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arbitration rule: first requesting index at or after ptr, circularly.
  function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Advance to the next falling edge and play the slave for the coming rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (apb_psel_out && apb_penable_out) acc_seen++;
    else acc_seen = 0;
    apb_ready_in  = (acc_seen > 0) && !slave_never && (acc_seen > slave_wait);
    apb_slverr_in = slave_err;
    apb_rdata_in  = slave_rdata;
  endtask

  task automatic wait_accept(output int g, output logic [N-1:0] v);
    g = -1;
    v = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (|req_ready_out) begin
        v = req_ready_out;
        for (int b = N - 1; b >= 0; b--) if (req_ready_out[b]) g = b;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic [N-1:0] v, output int acc);
    v = '0;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (apb_psel_out && apb_penable_out) acc++;
      if (|rsp_valid_out) begin
        v = rsp_valid_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({apb_psel_out, apb_penable_out} !== 2'b00) begin
      n_fail++; $display("FAIL reset_psel_penable: got %b required 00", {apb_psel_out, apb_penable_out});
    end
    n_checks++;
    if ({req_ready_out, rsp_valid_out} !== '0) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 0", {req_ready_out, rsp_valid_out});
    end
    n_checks++;
    if ({rsp_rdata_out, rsp_error_out} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got %h required 0", {rsp_rdata_out, rsp_error_out});
    end
    n_checks++;
    if ({apb_addr_out, apb_write_out, apb_wdata_out} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got %h required 0", {apb_addr_out, apb_write_out, apb_wdata_out});
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_read();
    req_addr[1*AW +: AW] = 32'h0000_0010;
    req_write[1] = 1'b0;
    slave_rdata = 32'hA5A5_0001;
    slave_wait = 0;
    slave_err = 1'b0;
    slave_never = 1'b0;
    req_valid = 4'b0010;
    tick();
    n_checks++;
    if ({apb_psel_out, apb_penable_out, req_ready_out} !== 6'b10_0010) begin
      n_fail++; $display("FAIL read_setup: psel/pen/ready got %b required 100010", {apb_psel_out, apb_penable_out, req_ready_out});
    end
    n_checks++;
    if ({apb_addr_out, apb_write_out} !== {32'h0000_0010, 1'b0}) begin
      n_fail++; $display("FAIL read_addr: got %h/%b required 00000010/0", apb_addr_out, apb_write_out);
    end
    req_valid = '0;
    tick();
    n_checks++;
    if ({apb_psel_out, apb_penable_out} !== 2'b11) begin
      n_fail++; $display("FAIL read_access: got %b required 11", {apb_psel_out, apb_penable_out});
    end
    tick();
    n_checks++;
    if ({apb_psel_out, apb_penable_out, rsp_valid_out} !== 6'b00_0010) begin
      n_fail++; $display("FAIL read_rsp_valid: got %b required 000010", {apb_psel_out, apb_penable_out, rsp_valid_out});
    end
    n_checks++;
    if ({rsp_rdata_out, rsp_error_out} !== {32'hA5A5_0001, 1'b0}) begin
      n_fail++; $display("FAIL read_rsp_data: got %h/%b required a5a50001/0", rsp_rdata_out, rsp_error_out);
    end
    model_ptr = 2;
  endtask

  task automatic test_round_robin();
    int g, exp_g, prev, acc;
    logic [N-1:0] v;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    prev = 0;
    slave_wait = 0;
    slave_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 32'h100 + 32'(i);
      req_write[i] = 1'b1;
      req_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_accept(g, v);
      exp_g = model_grant('1, model_ptr);
      n_checks++;
      if (g !== exp_g) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %0d required %0d", k, g, exp_g);
      end
      n_checks++;
      if ($onehot(v) !== 1'b1) begin
        n_fail++; $display("FAIL rr_onehot_%0d: got %b required one-hot", k, v);
      end
      if (k > 0) begin
        n_checks++;
        if (cyc - prev !== 3) begin
          n_fail++; $display("FAIL rr_gap_%0d: got %0d required 3", k, cyc - prev);
        end
      end
      prev = cyc;
      model_ptr = (exp_g + 1) % N;
      tick();
      n_checks++;
      if (req_ready_out !== '0) begin
        n_fail++; $display("FAIL rr_pulse_%0d: got %b required 0000", k, req_ready_out);
      end
    end
    req_valid = '0;
    wait_rsp(v, acc);
    n_checks++;
    if (v !== 4'b0001) begin
      n_fail++; $display("FAIL rr_last_rsp: got %b required 0001", v);
    end
  endtask

  task automatic test_write_wait_err();
    int g, nbus;
    bit wd_ok;
    logic [N-1:0] v;
    req_addr[2*AW +: AW] = 32'h0000_0020;
    req_write[2] = 1'b1;
    req_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    slave_wait = 3;
    slave_err = 1'b1;
    slave_rdata = 32'h1234_5678;
    req_valid = 4'b0100;
    wait_accept(g, v);
    n_checks++;
    if (g !== model_grant(4'b0100, model_ptr)) begin
      n_fail++; $display("FAIL wr_grant: got %0d required %0d", g, model_grant(4'b0100, model_ptr));
    end
    model_ptr = 3;
    req_valid = '0;
    nbus = apb_psel_out ? 1 : 0;
    wd_ok = (apb_wdata_out === 32'hDEAD_BEEF);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (|rsp_valid_out) break;
      if (apb_psel_out) begin
        nbus++;
        if (apb_wdata_out !== 32'hDEAD_BEEF) wd_ok = 1'b0;
      end
    end
    n_checks++;
    if (nbus !== 5 || !wd_ok) begin
      n_fail++; $display("FAIL wr_pwdata_stable: got %0d cycles ok=%0b required 5 ok=1", nbus, wd_ok);
    end
    n_checks++;
    if ({rsp_valid_out, rsp_error_out, rsp_rdata_out} !== {4'b0100, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wr_rsp: got %b/%b/%h required 0100/1/00000000", rsp_valid_out, rsp_error_out, rsp_rdata_out);
    end
    slave_err = 1'b0;
  endtask

  task automatic test_timeout();
    int g, acc;
    logic [N-1:0] v;
    req_addr[0 +: AW] = 32'h0000_0040;
    req_write[0] = 1'b0;
    slave_never = 1'b1;
    slave_rdata = 32'hFFFF_0000;
    req_valid = 4'b0001;
    wait_accept(g, v);
    n_checks++;
    if (g !== model_grant(4'b0001, model_ptr)) begin
      n_fail++; $display("FAIL to_grant: got %0d required %0d", g, model_grant(4'b0001, model_ptr));
    end
    model_ptr = 1;
    req_valid = '0;
    wait_rsp(v, acc);
    n_checks++;
    if (acc !== TO) begin
      n_fail++; $display("FAIL to_access_cycles: got %0d required %0d", acc, TO);
    end
    n_checks++;
    if ({apb_psel_out, v, rsp_error_out, rsp_rdata_out} !== {1'b0, 4'b0001, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL to_rsp: got psel=%b v=%b err=%b rd=%h required 0/0001/1/0", apb_psel_out, v, rsp_error_out, rsp_rdata_out);
    end
    slave_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g, acc;
    bit no_rsp;
    logic [N-1:0] v;
    req_addr[1*AW +: AW] = 32'h0000_0050;
    req_write[1] = 1'b0;
    slave_never = 1'b1;
    req_valid = 4'b0010;
    wait_accept(g, v);
    n_checks++;
    if (g !== model_grant(4'b0010, model_ptr)) begin
      n_fail++; $display("FAIL rm_grant: got %0d required %0d", g, model_grant(4'b0010, model_ptr));
    end
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({apb_psel_out, apb_penable_out, rsp_valid_out} !== '0) begin
      n_fail++; $display("FAIL rm_bus_drop: got %b required 000000", {apb_psel_out, apb_penable_out, rsp_valid_out});
    end
    rst = 1'b0;
    model_ptr = 0;
    slave_never = 1'b0;
    no_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid_out !== '0) no_rsp = 1'b0;
    end
    n_checks++;
    if (!no_rsp) begin
      n_fail++; $display("FAIL rm_no_rsp: got a response pulse, required none");
    end
    req_valid = '1;
    wait_accept(g, v);
    n_checks++;
    if (g !== model_grant('1, model_ptr)) begin
      n_fail++; $display("FAIL rm_regrant: got %0d required %0d", g, model_grant('1, model_ptr));
    end
    model_ptr = 1;
    req_valid = '0;
    wait_rsp(v, acc);
    n_checks++;
    if (v !== 4'b0001) begin
      n_fail++; $display("FAIL rm_rsp: got %b required 0001", v);
    end
  endtask

  task automatic test_withdraw();
    int g, r3, nrsp;
    logic [N-1:0] v;
    req_addr[0 +: AW] = 32'h0000_0060;
    req_write[0] = 1'b0;
    slave_wait = 4;
    req_valid = 4'b0001;
    wait_accept(g, v);
    n_checks++;
    if (g !== model_grant(4'b0001, model_ptr)) begin
      n_fail++; $display("FAIL wd_grant: got %0d required %0d", g, model_grant(4'b0001, model_ptr));
    end
    model_ptr = 1;
    req_valid = '0;
    tick();
    req_valid[3] = 1'b1;
    tick();
    req_valid[3] = 1'b0;
    r3 = 0;
    nrsp = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_ready_out[3]) r3++;
      if (rsp_valid_out === 4'b0001) nrsp++;
    end
    n_checks++;
    if (r3 !== 0) begin
      n_fail++; $display("FAIL wd_req3_ready: got %0d pulses required 0", r3);
    end
    n_checks++;
    if (nrsp !== 1) begin
      n_fail++; $display("FAIL wd_req0_rsp: got %0d responses required 1", nrsp);
    end
    slave_wait = 0;
  endtask

  task automatic test_random();
    int g, exp_g, acc, exp_acc;
    logic [N-1:0] v, mask;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = $urandom;
        req_write[i] = 1'($urandom_range(0, 1));
        req_wdata[i*DW +: DW] = $urandom;
      end
      slave_wait = $urandom_range(0, 4);
      slave_never = ($urandom_range(0, 5) == 0);
      slave_err = 1'($urandom_range(0, 1));
      slave_rdata = $urandom;
      exp_g = model_grant(mask, model_ptr);
      req_valid = mask;
      wait_accept(g, v);
      n_checks++;
      if (g !== exp_g || $onehot(v) !== 1'b1) begin
        n_fail++; $display("FAIL rnd_grant_%0d: got %0d (%b) required %0d", r, g, v, exp_g);
      end
      n_checks++;
      if ({apb_addr_out, apb_write_out, apb_wdata_out} !==
          {req_addr[exp_g*AW +: AW], req_write[exp_g], req_wdata[exp_g*DW +: DW]}) begin
        n_fail++; $display("FAIL rnd_payload_%0d: got %h/%b/%h required %h/%b/%h", r, apb_addr_out, apb_write_out,
                           apb_wdata_out, req_addr[exp_g*AW +: AW], req_write[exp_g], req_wdata[exp_g*DW +: DW]);
      end
      req_valid = '0;
      model_ptr = (exp_g + 1) % N;
      exp_acc = slave_never ? TO : slave_wait + 1;
      exp_err = slave_never ? 1'b1 : slave_err;
      exp_rd  = (slave_never || req_write[exp_g]) ? '0 : slave_rdata;
      wait_rsp(v, acc);
      n_checks++;
      if (v !== (N'(1) << exp_g) || acc !== exp_acc) begin
        n_fail++; $display("FAIL rnd_rsp_%0d: got %b after %0d cycles required %b after %0d", r, v, acc, N'(1) << exp_g, exp_acc);
      end
      n_checks++;
      if ({rsp_error_out, rsp_rdata_out} !== {exp_err, exp_rd}) begin
        n_fail++; $display("FAIL rnd_data_%0d: got %b/%h required %b/%h", r, rsp_error_out, rsp_rdata_out, exp_err, exp_rd);
      end
      slave_never = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_wait_err();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
